// File: rtl/xosera_bus_pkg.sv
// Shared types and defaults for the Xosera host-bus access controller.
package xosera_bus_pkg;

    // Default register-number width.
    localparam int REG_NUM_W_DEF = 4;

    // Bus access FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        RDWAIT = 2'd2,
        HOLD   = 2'd3
    } bus_state_e;

endpackage

// File: rtl/xosera_sync_ff.sv
// Single-bit synchronizer chain of parameterized depth.
// Asynchronous active-low reset loads every stage with RST_VAL.
module xosera_sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_q;

    // Shift the asynchronous input through the chain, stage 0 first.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= {DEPTH{RST_VAL}};
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/xosera_bus_ctrl.sv
// Xosera host-bus access controller: synchronizes bus select, captures one
// byte access per select assertion, pairs even/odd bytes into 16-bit register
// writes and serves 16-bit register reads one byte at a time.
// Optional read path: define XOSERA_BUS_READ_EN (default build is write-only).
module xosera_bus_ctrl
    import xosera_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int REG_NUM_W   = REG_NUM_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n_i,
    input  logic                 bus_sel_n_i,
    input  logic                 bus_rd_nwr_i,
    input  logic                 bus_bytesel_i,
    input  logic [REG_NUM_W-1:0] bus_reg_num_i,
    input  logic [7:0]           bus_data_i,
    output logic [7:0]           bus_data_o,
    output logic                 reg_wr_o,
    output logic                 reg_rd_o,
    output logic [REG_NUM_W-1:0] reg_num_o,
    output logic [15:0]          reg_data_o,
    input  logic [15:0]          reg_data_i
);

    // The FSM's own state register acts as the last synchronizer stage, so the
    // dedicated chain is one flop shorter; capture then lands on edge SYNC_STAGES.
    localparam int SYNC_DEPTH = SYNC_STAGES - 1;

    logic                 sel_n_sync;
    bus_state_e           state_q, state_d;
    logic                 capture;
    logic                 wr_stb;
    logic                 cap_rd_q;
    logic                 cap_bsel_q;
    logic [REG_NUM_W-1:0] cap_num_q;
    logic [7:0]           cap_data_q;
    logic [7:0]           msb_q;
    logic [REG_NUM_W-1:0] reg_num_q;
    logic [15:0]          reg_data_q;
`ifdef XOSERA_BUS_READ_EN
    logic                 rd_stb;
    logic [15:0]          rd_latch_q;
`else
    logic                 unused_rd_data;
`endif

    xosera_sync_ff #(
        .DEPTH   (SYNC_DEPTH),
        .RST_VAL (1'b1)
    ) u_sel_sync (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .d_i       (bus_sel_n_i),
        .q_o       (sel_n_sync)
    );

    assign capture = (state_q == IDLE) && !sel_n_sync;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state decode and one-cycle strobes issued from DECODE.
    always_comb begin
        state_d = state_q;
        wr_stb  = 1'b0;
`ifdef XOSERA_BUS_READ_EN
        rd_stb  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!sel_n_sync) state_d = DECODE;
            end
            DECODE: begin
                state_d = HOLD;
                if (!cap_rd_q) begin
                    wr_stb = cap_bsel_q;
                end
`ifdef XOSERA_BUS_READ_EN
                else if (!cap_bsel_q) begin
                    rd_stb  = 1'b1;
                    state_d = RDWAIT;
                end
`endif
            end
            RDWAIT: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (sel_n_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample the unsynchronized bus inputs once, at the capture edge.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cap_rd_q   <= 1'b0;
            cap_bsel_q <= 1'b0;
            cap_num_q  <= '0;
            cap_data_q <= 8'h00;
        end else if (capture) begin
            cap_rd_q   <= bus_rd_nwr_i;
            cap_bsel_q <= bus_bytesel_i;
            cap_num_q  <= bus_reg_num_i;
            cap_data_q <= bus_data_i;
        end
    end

    // Even-byte latch plus held copies of the last strobed index and data.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            msb_q      <= 8'h00;
            reg_num_q  <= '0;
            reg_data_q <= 16'h0000;
        end else begin
            if (state_q == DECODE && !cap_rd_q && !cap_bsel_q) begin
                msb_q <= cap_data_q;
            end
            if (wr_stb) begin
                reg_num_q  <= cap_num_q;
                reg_data_q <= {msb_q, cap_data_q};
            end
`ifdef XOSERA_BUS_READ_EN
            if (rd_stb) begin
                reg_num_q <= cap_num_q;
            end
`endif
        end
    end

    // During the strobe cycle show the new values; afterwards the held copies.
    assign reg_wr_o   = wr_stb;
    assign reg_data_o = wr_stb ? {msb_q, cap_data_q} : reg_data_q;

`ifdef XOSERA_BUS_READ_EN
    // Latch the full 16-bit word so an odd read returns the matching LSB.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i)              rd_latch_q <= 16'h0000;
        else if (state_q == RDWAIT)  rd_latch_q <= reg_data_i;
    end

    assign reg_rd_o   = rd_stb;
    assign reg_num_o  = (wr_stb || rd_stb) ? cap_num_q : reg_num_q;
    assign bus_data_o = cap_bsel_q ? rd_latch_q[7:0] : rd_latch_q[15:8];
`else
    assign reg_rd_o       = 1'b0;
    assign reg_num_o      = wr_stb ? cap_num_q : reg_num_q;
    assign bus_data_o     = 8'h00;
    assign unused_rd_data = ^reg_data_i;
`endif

endmodule

// File: tb/tb_xosera_bus_ctrl.sv
// Directed self-checking bench for xosera_bus_ctrl (SYNC_STAGES=2).
// Read-path checks follow XOSERA_BUS_READ_EN; otherwise the write-only build
// is checked for an inert read.
module tb_xosera_bus_ctrl;
    import xosera_bus_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        sel_n;
    logic        rd_nwr;
    logic        bytesel;
    logic [3:0]  reg_num;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        reg_wr;
    logic        reg_rd;
    logic [3:0]  rnum;
    logic [15:0] rdata_o;
    logic [15:0] rdata_i;

    int          total = 0;
    int          bad   = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [3:0]  last_wr_num = 4'h0;
    logic [15:0] last_wr_data = 16'h0;
    logic [3:0]  last_rd_num = 4'h0;

    xosera_bus_ctrl #(
        .SYNC_STAGES (2),
        .REG_NUM_W   (4)
    ) dut (
        .clk           (clk),
        .reset_n_i     (rst_n),
        .bus_sel_n_i   (sel_n),
        .bus_rd_nwr_i  (rd_nwr),
        .bus_bytesel_i (bytesel),
        .bus_reg_num_i (reg_num),
        .bus_data_i    (din),
        .bus_data_o    (dout),
        .reg_wr_o      (reg_wr),
        .reg_rd_o      (reg_rd),
        .reg_num_o     (rnum),
        .reg_data_o    (rdata_o),
        .reg_data_i    (rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_num  <= rnum;
            last_wr_data <= rdata_o;
        end
        if (reg_rd) begin
            rd_cnt      <= rd_cnt + 1;
            last_rd_num <= rnum;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd, input logic bsel, input logic [3:0] num,
                          input logic [7:0] data, input int low_cyc, input int high_cyc);
        @(negedge clk);
        sel_n = 1'b0; rd_nwr = rd; bytesel = bsel; reg_num = num; din = data;
        repeat (low_cyc) @(negedge clk);
        sel_n = 1'b1;
        repeat (high_cyc) @(negedge clk);
    endtask

    initial begin
        sel_n = 1'b1; rd_nwr = 1'b0; bytesel = 1'b0; reg_num = 4'h0; din = 8'h00;
        rdata_i = 16'h0000; rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_wr",   {15'h0, reg_wr}, 16'h0);
        chk("rst_rd",   {15'h0, reg_rd}, 16'h0);
        chk("rst_num",  {12'h0, rnum},   16'h0);
        chk("rst_data", rdata_o,         16'h0);
        chk("rst_dout", {8'h0, dout},    16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // odd-only write right after reset uses the cleared MSB latch
        access(1'b0, 1'b1, 4'd5, 8'h12, 6, 4);
        chk("oddonly_cnt",  16'(wr_cnt), 16'd1);
        chk("oddonly_num",  {12'h0, last_wr_num}, 16'd5);
        chk("oddonly_data", last_wr_data, 16'h0012);

        // even then odd write pair
        access(1'b0, 1'b0, 4'd3, 8'hAB, 6, 4);
        chk("even_nostrobe", 16'(wr_cnt), 16'd1);
        access(1'b0, 1'b1, 4'd3, 8'hCD, 6, 4);
        chk("pair_cnt",   16'(wr_cnt), 16'd2);
        chk("pair_num",   {12'h0, last_wr_num}, 16'd3);
        chk("pair_data",  last_wr_data, 16'hABCD);
        chk("pair_hold",  rdata_o, 16'hABCD);
        chk("pair_hnum",  {12'h0, rnum}, 16'd3);
        chk("pair_nord",  16'(rd_cnt), 16'd0);

        // strobe lands exactly one cycle after the capture edge (edge 2)
        @(negedge clk);
        sel_n = 1'b0; rd_nwr = 1'b0; bytesel = 1'b1; reg_num = 4'd9; din = 8'h3C;
        @(negedge clk);
        chk("lat_e1", {15'h0, reg_wr}, 16'h0);
        @(negedge clk);
        chk("lat_e2",   {15'h0, reg_wr}, 16'h1);
        chk("lat_data", rdata_o, 16'hAB3C);
        chk("lat_num",  {12'h0, rnum}, 16'd9);
        @(negedge clk);
        chk("lat_e3", {15'h0, reg_wr}, 16'h0);
        repeat (3) @(negedge clk);
        sel_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("lat_cnt", 16'(wr_cnt), 16'd3);

        // long select: one action only; minimum deselect then a second access
        access(1'b0, 1'b1, 4'd1, 8'h77, 50, 3);
        chk("long_cnt",  16'(wr_cnt), 16'd4);
        chk("long_data", last_wr_data, 16'hAB77);
        access(1'b0, 1'b1, 4'd2, 8'h66, 6, 4);
        chk("again_cnt",  16'(wr_cnt), 16'd5);
        chk("again_data", last_wr_data, 16'hAB66);

        // reset right after capture of an odd write
        @(negedge clk);
        sel_n = 1'b0; rd_nwr = 1'b0; bytesel = 1'b1; reg_num = 4'd2; din = 8'h99;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_wr",   {15'h0, reg_wr}, 16'h0);
        chk("mrst_rd",   {15'h0, reg_rd}, 16'h0);
        chk("mrst_num",  {12'h0, rnum},   16'h0);
        chk("mrst_data", rdata_o,         16'h0);
        chk("mrst_dout", {8'h0, dout},    16'h0);
        sel_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_nostrobe", 16'(wr_cnt), 16'd5);
        access(1'b0, 1'b1, 4'd4, 8'h55, 6, 4);
        chk("mrst_cnt",  16'(wr_cnt), 16'd6);
        chk("mrst_after", last_wr_data, 16'h0055);
        chk("mrst_anum",  {12'h0, last_wr_num}, 16'd4);

`ifdef XOSERA_BUS_READ_EN
        // even read latches the whole word; odd read returns its LSB
        rdata_i = 16'h1234;
        @(negedge clk);
        sel_n = 1'b0; rd_nwr = 1'b1; bytesel = 1'b0; reg_num = 4'd7;
        repeat (3) @(negedge clk);
        chk("rd_early", {8'h0, dout}, 16'h0000);
        @(negedge clk);
        chk("rd_even",   {8'h0, dout}, 16'h0012);
        chk("rd_cnt1",   16'(rd_cnt), 16'd1);
        chk("rd_num",    {12'h0, last_rd_num}, 16'd7);
        rdata_i = 16'hFFFF;
        repeat (2) @(negedge clk);
        sel_n = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk);
        sel_n = 1'b0; rd_nwr = 1'b1; bytesel = 1'b1; reg_num = 4'd7;
        repeat (3) @(negedge clk);
        chk("rd_odd",   {8'h0, dout}, 16'h0034);
        repeat (3) @(negedge clk);
        sel_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rd_cnt2",  16'(rd_cnt), 16'd1);
        chk("rd_nowr",  16'(wr_cnt), 16'd6);
`else
        // write-only build: a read has no effect and the FSM returns to IDLE
        rdata_i = 16'h1234;
        @(negedge clk);
        sel_n = 1'b0; rd_nwr = 1'b1; bytesel = 1'b0; reg_num = 4'd7;
        repeat (4) @(negedge clk);
        chk("nord_dout", {8'h0, dout}, 16'h0000);
        chk("nord_rd",   {15'h0, reg_rd}, 16'h0);
        repeat (2) @(negedge clk);
        sel_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("nord_idle", {14'h0, dut.state_q}, {14'h0, IDLE});
        chk("nord_rcnt", 16'(rd_cnt), 16'd0);
        chk("nord_wcnt", 16'(wr_cnt), 16'd6);
        chk("nord_hold", rdata_o, 16'h0055);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
